bcd_stopwatch: RTL

- Consumes the 100 Hz square wave from the clock divider and runs a seconds/centiseconds stopwatch in BCD (SS.CC, 00.00–59.99).
- Start/stop, clear and lap controls come from upstream debounced one-pulse button logic.
- BCD digits feed the 7-segment scan stage.
- All logic runs on the system clock. The 100 Hz wave is edge-detected and used as an enable, never as a clock.

---
 rtl/bcd_stopwatch.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch: SS.CC stopwatch in BCD (00.00 .. SEC_TENS_MAX9.99), advanced
// by the rising edge of a 100 Hz square wave used as an enable on clk.
//
// Optional feature macro: STOPWATCH_LAP_EN (adds the LAP state; the display
// freezes while the internal count keeps running).
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   clk_100      100 Hz square wave, a clk-domain register output
//   start_stop   single-cycle pulse: toggle run/pause
//   clear        single-cycle pulse: zero the count when not running
//   lap          single-cycle pulse: enter/leave lap hold (feature only)
//   digit3..0    displayed digits, SS.CC, BCD
//   running      high in RUN or LAP
//   wrap         one-cycle pulse, aligned with the display showing 00.00
//   lap_hold     high while the display is frozen
module bcd_stopwatch #(
    parameter int SEC_TENS_MAX = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_100,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] digit3,
    output logic [3:0] digit2,
    output logic [3:0] digit1,
    output logic [3:0] digit0,
    output logic       running,
    output logic       wrap,
    output logic       lap_hold
);

    localparam logic [3:0] D3_MAX = 4'(SEC_TENS_MAX);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;

    state_t           state_q, state_d;
    logic             clk_100_q, clk_100_d;
    logic [3:0][3:0]  cnt_q, cnt_d;    // live count, [0] = centiseconds ones
    logic [3:0][3:0]  disp_q, disp_d;  // displayed digits, one cycle behind cnt
    logic             roll_q, roll_d;  // count rolled over on the last edge
    logic             wrap_q, wrap_d;
    logic             running_q, running_d;
    logic             lap_hold_q, lap_hold_d;

    logic             tick;
    logic             counting;
    logic             carry;
    logic [3:0][3:0]  inc;

    always_comb begin
        clk_100_d = clk_100;
        tick      = clk_100 & ~clk_100_q;
        counting  = (state_q == RUN) || (state_q == LAP);

        // BCD ripple increment; digit3 wraps at D3_MAX instead of 9
        inc   = cnt_q;
        carry = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (carry) begin
                if (cnt_q[i] == 4'd9) begin
                    inc[i] = 4'd0;
                end else begin
                    inc[i] = cnt_q[i] + 4'd1;
                    carry  = 1'b0;
                end
            end
        end
        roll_d = 1'b0;
        if (carry) begin
            if (cnt_q[3] == D3_MAX) inc[3] = 4'd0;
            else                    inc[3] = cnt_q[3] + 4'd1;
        end

        state_d = state_q;
        cnt_d   = cnt_q;
        if (tick && counting) begin
            cnt_d  = inc;
            roll_d = carry && (cnt_q[3] == D3_MAX);
        end

        // start_stop in IDLE/PAUSE sees counting=0, so a coincident tick is dropped
        case (state_q)
            IDLE: begin
                if (start_stop)  state_d = RUN;
                else if (clear)  cnt_d   = '0;
            end
            RUN: begin
                if (start_stop)  state_d = PAUSE;
`ifdef STOPWATCH_LAP_EN
                else if (lap)    state_d = LAP;
`endif
            end
            PAUSE: begin
                if (clear) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (start_stop) begin
                    state_d = RUN;
                end
            end
`ifdef STOPWATCH_LAP_EN
            LAP: begin
                if (start_stop)  state_d = PAUSE;
                else if (lap)    state_d = RUN;
            end
`endif
            default: state_d = IDLE;
        endcase

`ifdef STOPWATCH_LAP_EN
        // On the entry edge state_q is still RUN, so the live count is captured
        disp_d     = (state_q == LAP) ? disp_q : cnt_q;
        lap_hold_d = (state_d == LAP);
`else
        disp_d     = cnt_q;
        lap_hold_d = 1'b0;
`endif
        running_d = (state_d == RUN) || (state_d == LAP);
        wrap_d    = roll_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            clk_100_q  <= 1'b0;
            cnt_q      <= '0;
            disp_q     <= '0;
            roll_q     <= 1'b0;
            wrap_q     <= 1'b0;
            running_q  <= 1'b0;
            lap_hold_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_100_q  <= clk_100_d;
            cnt_q      <= cnt_d;
            disp_q     <= disp_d;
            roll_q     <= roll_d;
            wrap_q     <= wrap_d;
            running_q  <= running_d;
            lap_hold_q <= lap_hold_d;
        end
    end

`ifndef STOPWATCH_LAP_EN
    logic unused_lap;
    assign unused_lap = lap ^ lap_hold_q;
`endif

    assign digit3   = disp_q[3];
    assign digit2   = disp_q[2];
    assign digit1   = disp_q[1];
    assign digit0   = disp_q[0];
    assign running  = running_q;
    assign wrap     = wrap_q;
`ifdef STOPWATCH_LAP_EN
    assign lap_hold = lap_hold_q;
`else
    assign lap_hold = 1'b0;
`endif

endmodule
